ram_burst_reader: RTL and testbench
===================================

# ram_burst_reader

Burst read controller that sits directly upstream of the `ram_reader` memory and drives its address, oe and we ports. On a start request it reads `i_w_length` consecutive words from `i_w_base` and delivers them in order on a valid/ready output stream. A 4-entry internal FIFO absorbs the RAM's one-cycle read latency, so the block sustains one word per cycle while `i_w_ready` is held high and never loses data under backpressure.

## Interface

Parameters:
- p_data_width, 8, word width; must match the RAM.
- p_address_width, 10, RAM address width; must match the RAM.

Ports:
- i_w_clk  input  1  clock; all state updates on the rising edge.
- i_w_rst_n  input  1  reset; one clock, asynchronous, active-low.
- i_w_start  input  1  start request; sampled only in IDLE.
- i_w_base  input  p_address_width  first address; latched on an accepted start.
- i_w_length  input  p_address_width+1  word count, 0..2^p_address_width; latched on an accepted start.
- o_w_busy  output  1  high from the cycle after an accepted start until DONE.
- o_w_done  output  1  one-cycle pulse when the burst completes.
- o_w_address  output  p_address_width  RAM address.
- o_w_oe  output  1  RAM read enable; high only in cycles that issue a read.
- o_w_we  output  1  RAM write enable; constant 0.
- o_w_ram_in  output  p_data_width  RAM write data; constant 0.
- i_w_ram_out  input  p_data_width  RAM read data.
- o_w_data  output  p_data_width  stream data, taken from the FIFO head.
- o_w_valid  output  1  stream valid; high when the FIFO is not empty.
- i_w_ready  input  1  stream ready from the consumer.

## Operation

- States:
  - IDLE -> ISSUE on i_w_start=1 with length≠0.
  - IDLE -> DONE on i_w_start=1 with length=0.
  - ISSUE -> DRAIN when the last read has been issued.
  - DRAIN -> DONE on the handshake that delivers the last word.
  - DONE -> IDLE unconditionally after 1 cycle.
- Read issue in cycle c:
  - Allowed only in ISSUE, and only when occupancy + inflight + 1 ≤ 4.
  - occupancy is the FIFO count at the start of cycle c. A pop in the same cycle is not credited.
  - inflight is 1 if a read was issued in cycle c-1, otherwise 0.
  - When a read issues: o_w_oe=1 and o_w_address=current address. When no read issues: o_w_oe=0 and o_w_address holds its value.
- RAM contract: data for a read issued in cycle c is on i_w_ram_out during cycle c+1, and is pushed into the FIFO at the end of c+1.
- Addressing: the address increments modulo 2^p_address_width after each issue. Base 1020 with length 6 reads 1020..1023, then 0, 1.
- Counters:
  - The issue counter and the delivered counter are each p_address_width+1 bits wide.
  - The burst ends when delivered = latched length.
- Handshake:
  - A word transfers when o_w_valid=1 and i_w_ready=1.
  - o_w_data is stable while o_w_valid=1 and i_w_ready=0.
  - A push and a pop in the same cycle leave occupancy unchanged.
- i_w_start is ignored while busy (any state other than IDLE). i_w_base and i_w_length are don't-care outside an accepted start.

## Timing

- Reset values: o_w_busy=0, o_w_done=0, o_w_address=0, o_w_oe=0, o_w_valid=0, o_w_data=0. FIFO empty, state IDLE.
- Start accepted at edge E:
  - First read (oe=1, address=base) in the cycle after E.
  - Data pushed at the end of the following cycle.
  - o_w_valid=1 in the third cycle after E.
- With i_w_ready held at 1, one word transfers per cycle after the first. An N-word burst has o_w_done in cycle E+N+3.
- Length 0: o_w_done pulses in the cycle after E, and o_w_busy never rises.
- o_w_done and the DONE state last exactly 1 cycle. o_w_busy is 0 in the DONE cycle. A new start is accepted from the following cycle (IDLE).
- Reset asserted mid-burst: all outputs return to their reset values immediately. FIFO contents and in-flight data are discarded.

## Configuration

- RAM_BURST_READER_CHECKSUM_EN defined:
  - Adds output o_w_checksum [p_data_width].
  - Cleared to 0 on an accepted start.
  - XOR-accumulates each delivered word on its handshake.
  - Valid in the o_w_done cycle; holds until the next accepted start.
- Macro not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan

- RAM preloaded with mem[a]=a&0xFF; base=2, length=4, ready=1 -> stream 2,3,4,5 on consecutive cycles; o_w_done at E+7; o_w_oe high for exactly 4 cycles.
- Base=1022, length=4 -> o_w_address sequence 1022, 1023, 0, 1; data 254, 255, 0, 1.
- Length=8, ready toggled 1,0,0,1,...:
  - Required: all 8 words delivered in order, none duplicated.
  - Required: o_w_data stable while stalled.
  - Required: o_w_oe never issues when occupancy+inflight=4.
- Length=0 -> o_w_done pulse at E+1; o_w_oe and o_w_valid stay 0; a new start at E+2 is accepted.
- i_w_rst_n pulled low after 3 words of a 10-word burst -> outputs return to reset values asynchronously; a fresh start afterwards delivers from the new base.
- With CHECKSUM_EN: words 0x0F, 0xF0, 0x33 -> o_w_checksum=0xCC at o_w_done.

Source files
------------

// File: rtl/ram_burst_reader.sv
// Burst read controller for a one-cycle-latency RAM, with a 4-entry output FIFO.
// Optional XOR checksum of delivered words: define RAM_BURST_READER_CHECKSUM_EN.
module ram_burst_reader #(
  parameter int p_data_width    = 8,
  parameter int p_address_width = 10
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_rst_n,
  input  logic                       i_w_start,
  input  logic [p_address_width-1:0] i_w_base,
  input  logic [p_address_width:0]   i_w_length,
  output logic                       o_w_busy,
  output logic                       o_w_done,
  output logic [p_address_width-1:0] o_w_address,
  output logic                       o_w_oe,
  output logic                       o_w_we,
  output logic [p_data_width-1:0]    o_w_ram_in,
  input  logic [p_data_width-1:0]    i_w_ram_out,
  output logic [p_data_width-1:0]    o_w_data,
  output logic                       o_w_valid,
`ifdef RAM_BURST_READER_CHECKSUM_EN
  output logic [p_data_width-1:0]    o_w_checksum,
`endif
  input  logic                       i_w_ready
);

  localparam int LW = p_address_width + 1;
  localparam logic [LW-1:0] ONE = LW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     state_q;
  logic [p_address_width-1:0] next_addr_q;
  logic [p_address_width-1:0] hold_addr_q;
  logic [LW-1:0]              length_q;
  logic [LW-1:0]              issued_q;
  logic [LW-1:0]              delivered_q;
  logic                       inflight_q;
  logic [1:0]                 wr_ptr_q;
  logic [1:0]                 rd_ptr_q;
  logic [2:0]                 count_q;
  logic [p_data_width-1:0]    fifo_q [4];

  logic issue;
  logic push;
  logic pop;

  // A read may issue only if the FIFO has room for it plus any word still in flight.
  always_comb begin
    issue = (state_q == S_ISSUE) && ((count_q + {2'b00, inflight_q}) < 3'd4);
    push  = inflight_q;
    pop   = (count_q != 3'd0) && i_w_ready;
  end

  assign o_w_busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign o_w_done    = (state_q == S_DONE);
  assign o_w_oe      = issue;
  assign o_w_address = issue ? next_addr_q : hold_addr_q;
  assign o_w_we      = 1'b0;
  assign o_w_ram_in  = '0;
  assign o_w_valid   = (count_q != 3'd0);
  assign o_w_data    = o_w_valid ? fifo_q[rd_ptr_q] : '0;

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q     <= S_IDLE;
      next_addr_q <= '0;
      hold_addr_q <= '0;
      length_q    <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        hold_addr_q <= next_addr_q;
        next_addr_q <= next_addr_q + 1'b1;
        issued_q    <= issued_q + ONE;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + 2'd1;
        delivered_q <= delivered_q + ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase

      case (state_q)
        S_IDLE: begin
          if (i_w_start) begin
            length_q    <= i_w_length;
            next_addr_q <= i_w_base;
            issued_q    <= '0;
            delivered_q <= '0;
            state_q     <= (i_w_length == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue && ((issued_q + ONE) == length_q)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && ((delivered_q + ONE) == length_q)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO storage carries data only; emptiness is tracked by count_q.
  always_ff @(posedge i_w_clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= i_w_ram_out;
    end
  end

`ifdef RAM_BURST_READER_CHECKSUM_EN
  logic [p_data_width-1:0] checksum_q;

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      checksum_q <= '0;
    end else if ((state_q == S_IDLE) && i_w_start) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q ^ o_w_data;
    end
  end

  assign o_w_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomized bench for ram_burst_reader: a queue-based stream model plus a RAM model.
module tb_ram_burst_reader;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   length = '0;
  logic          ready = 1'b0;
  logic [DW-1:0] ram_out = '0;
  logic          busy, done, oe, we, valid;
  logic [AW-1:0] address;
  logic [DW-1:0] ram_in, data;
`ifdef RAM_BURST_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  ram_burst_reader #(.p_data_width(DW), .p_address_width(AW)) dut (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_start(start), .i_w_base(base),
    .i_w_length(length), .o_w_busy(busy), .o_w_done(done), .o_w_address(address),
    .o_w_oe(oe), .o_w_we(we), .o_w_ram_in(ram_in), .i_w_ram_out(ram_out),
    .o_w_data(data), .o_w_valid(valid),
`ifdef RAM_BURST_READER_CHECKSUM_EN
    .o_w_checksum(checksum),
`endif
    .i_w_ready(ready)
  );

  always #5 clk = ~clk;

  // RAM: one-cycle read latency
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (oe) ram_out <= mem[address];

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Model state
  bit            chk_en = 1'b0;
  bit            m_busy = 1'b0;
  bit            m_done_now = 1'b0;
  int            m_len = 0, m_iss = 0, m_deliv = 0;
  logic [AW-1:0] m_base = '0;
  logic [DW-1:0] m_chk = '0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] log_q[$];
  logic [AW-1:0] addr_log[$];
  int            cyc = 0;
  int            start_cyc = 0, done_cyc = -1, first_valid_cyc = -1, oe_cnt = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] ea;
  bit            cur_busy, cur_done, last_hs;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      cur_busy = m_busy;
      cur_done = m_done_now;
      last_hs  = 1'b0;
      check("busy", 32'(busy), 32'(cur_busy));
      check("done", 32'(done), 32'(cur_done));
      check("we", 32'(we), 32'd0);
      check("ram_in", 32'(ram_in), 32'd0);
      if (done) done_cyc = cyc;
`ifdef RAM_BURST_READER_CHECKSUM_EN
      if (cur_done) check("checksum", 32'(checksum), 32'(m_chk));
`endif
      if (oe) begin
        check("oe_in_burst", 32'(cur_busy && (m_iss < m_len)), 32'd1);
        check("oe_credit", 32'(m_iss - m_deliv <= 3), 32'd1);
        ea = m_base + AW'(m_iss);
        check("address", 32'(address), 32'(ea));
        addr_log.push_back(address);
        m_iss++;
        oe_cnt++;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(valid), 32'd1);
        check("stall_data", 32'(data), 32'(prev_data));
      end
      if (valid) begin
        check("valid_has_word", 32'(exp_q.size() > 0), 32'd1);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (valid && ready && exp_q.size() > 0) begin
        check("data", 32'(data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        log_q.push_back(data);
        m_chk = m_chk ^ data;
        m_deliv++;
        if (m_deliv == m_len) last_hs = 1'b1;
      end
      prev_stall = valid && !ready;
      prev_data  = data;

      m_done_now = 1'b0;
      if (last_hs) begin
        m_busy     = 1'b0;
        m_done_now = 1'b1;
      end else if (start && !cur_busy && !cur_done) begin
        m_len   = int'(length);
        m_base  = base;
        m_iss   = 0;
        m_deliv = 0;
        m_chk   = '0;
        exp_q.delete();
        log_q.delete();
        addr_log.delete();
        for (int i = 0; i < m_len; i++) exp_q.push_back(mem[base + AW'(i)]);
        start_cyc       = cyc + 1;
        first_valid_cyc = -1;
        oe_cnt          = 0;
        if (m_len == 0) m_done_now = 1'b1;
        else            m_busy     = 1'b1;
      end
    end
  end

  function automatic logic rdy(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3) == 0;
    return $urandom_range(0, 9) < 6;
  endfunction

  // Called at #1 after a rising edge in an IDLE cycle; returns likewise.
  task automatic run_burst(input logic [AW-1:0] b, input int n, input int mode);
    int k;
    int budget;
    start  = 1'b1;
    base   = b;
    length = (AW+1)'(n);
    ready  = rdy(mode, 0);
    @(posedge clk); #1;
    start  = 1'b0;
    k      = 1;
    budget = n * 8 + 60;
    while (!done && budget > 0) begin
      ready = rdy(mode, k);
      k++;
      if (mode == 2 && $urandom_range(0, 3) == 0) begin
        start  = 1'b1;
        base   = AW'($urandom);
        length = (AW+1)'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      budget--;
    end
    check("done_seen", 32'(done), 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  int s0;
  int budget;

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Basic 4-word burst at full rate
    run_burst(10'd2, 4, 0);
    check("t1_w0", 32'(log_q[0]), 32'd2);
    check("t1_w1", 32'(log_q[1]), 32'd3);
    check("t1_w2", 32'(log_q[2]), 32'd4);
    check("t1_w3", 32'(log_q[3]), 32'd5);
    check("t1_done_lat", 32'(done_cyc - start_cyc), 32'd6);
    check("t1_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd2);
    check("t1_oe_cnt", 32'(oe_cnt), 32'd4);

    // Address wrap
    run_burst(10'd1022, 4, 0);
    check("t2_a0", 32'(addr_log[0]), 32'd1022);
    check("t2_a1", 32'(addr_log[1]), 32'd1023);
    check("t2_a2", 32'(addr_log[2]), 32'd0);
    check("t2_a3", 32'(addr_log[3]), 32'd1);
    check("t2_d0", 32'(log_q[0]), 32'd254);
    check("t2_d1", 32'(log_q[1]), 32'd255);
    check("t2_d2", 32'(log_q[2]), 32'd0);
    check("t2_d3", 32'(log_q[3]), 32'd1);

    // Backpressure with ready 1,0,0,...
    run_burst(10'd500, 8, 1);
    check("t3_count", 32'(log_q.size()), 32'd8);
    check("t3_first", 32'(log_q[0]), 32'd244);
    check("t3_last", 32'(log_q[7]), 32'd251);

    // Zero length, then an immediate restart two cycles later
    run_burst(10'd7, 0, 0);
    s0 = start_cyc;
    check("t4_done_lat", 32'(done_cyc - start_cyc), 32'd0);
    check("t4_oe_cnt", 32'(oe_cnt), 32'd0);
    run_burst(10'd10, 3, 0);
    check("t4_restart", 32'(start_cyc - s0), 32'd2);
    check("t4_w0", 32'(log_q[0]), 32'd10);

    // Asynchronous reset mid-burst
    start  = 1'b1;
    base   = 10'd40;
    length = 11'd10;
    ready  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    budget = 40;
    while (m_deliv < 3 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("t5_reached3", 32'(m_deliv >= 3), 32'd1);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_address", 32'(address), 32'd0);
    check("t5_oe", 32'(oe), 32'd0);
    check("t5_valid", 32'(valid), 32'd0);
    check("t5_data", 32'(data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    m_busy     = 1'b0;
    m_done_now = 1'b0;
    m_iss      = 0;
    m_deliv    = 0;
    m_len      = 0;
    exp_q.delete();
    prev_stall = 1'b0;
    chk_en     = 1'b1;
    @(posedge clk); #1;
    run_burst(10'd300, 5, 2);
    check("t5_new_w0", 32'(log_q[0]), 32'd44);
    check("t5_new_count", 32'(log_q.size()), 32'd5);

`ifdef RAM_BURST_READER_CHECKSUM_EN
    mem[100] = 8'h0F;
    mem[101] = 8'hF0;
    mem[102] = 8'h33;
    run_burst(10'd100, 3, 0);
    check("t6_checksum", 32'(checksum), 32'hCC);
`endif

    // Random contents, bases, lengths and ready patterns
    for (int a = 0; a < DEPTH; a++) mem[a] = DW'($urandom);
    for (int t = 0; t < 30; t++) begin
      run_burst(AW'($urandom), $urandom_range(0, 40), $urandom_range(0, 2));
    end
    run_burst(AW'($urandom), DEPTH, 0);
    check("t7_full_count", 32'(log_q.size()), 32'(DEPTH));
    check("t7_full_lat", 32'(done_cyc - start_cyc), 32'(DEPTH + 2));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
